instr_fetch: RTL and testbench



---
 rtl/divvy_pkg.sv | 52 +++++
 rtl/fetch_hold.sv | 70 +++++++
 rtl/instr_fetch.sv | 161 ++++++++++++++++
 tb/tb_instr_fetch.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/divvy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : divvy_pkg
//  Description : Shared definitions for the Divvy CPU front end.
//                - Default program-counter and instruction widths.
//                - Fetch sequencer state encoding.
//                - Opcode encoding shared with the control decoder.
//                  Keeping it here gives the HLT encoding a single home.
//                - Instruction field positions: opcode in [8:5], flag in [4].
//  Revision    : 1.0 - initial release
// ============================================================================
package divvy_pkg;

  localparam int DIVVY_PC_W = 10;
  localparam int DIVVY_IW   = 9;

  // Instruction field positions
  localparam int OPC_MSB  = 8;
  localparam int OPC_LSB  = 5;
  localparam int FLAG_BIT = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    HALTED   = 2'd3
  } fetch_state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_LD  = 4'h2,
    OP_ST  = 4'h3,
    OP_ADD = 4'h4,
    OP_SUB = 4'h5,
    OP_AND = 4'h6,
    OP_OR  = 4'h7,
    OP_XOR = 4'h8,
    OP_SHF = 4'h9,
    OP_CMP = 4'hA,
    OP_BR  = 4'hB,
    OP_JMP = 4'hC,
    OP_HLT = 4'hF
  } opcode_t;

  // True when an instruction word carries the HLT opcode.
  function automatic logic is_hlt(input logic [DIVVY_IW-1:0] instr);
    return opcode_t'(instr[OPC_MSB:OPC_LSB]) == OP_HLT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_hold.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_hold
//  Description : Single-entry hold register for the fetch stage.
//                - Captures the presented instruction and PC on the first
//                  stalled cycle.
//                - While full, a bypass mux shows the held pair instead of
//                  the live pair.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                capture       - stall seen while an instruction is shown
//                clear         - shown instruction accepted, entry freed
//                in_instr/in_pc   - live instruction word and its PC
//                out_instr/out_pc - bypassed instruction word and PC
//                held          - entry currently full
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_hold
  import divvy_pkg::*;
#(
  parameter int IW   = DIVVY_IW,
  parameter int PC_W = DIVVY_PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture,
  input  logic            clear,
  input  logic [IW-1:0]   in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic [IW-1:0]   out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic            held
);

  logic            held_q,  held_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic [PC_W-1:0] pc_q,    pc_d;

  always_comb begin
    held_d  = held_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      held_d = 1'b0;
    end else if (capture && !held_q) begin
      // Only the first stalled cycle loads. After that, the live memory
      // port already shows the following word.
      held_d  = 1'b1;
      instr_d = in_instr;
      pc_d    = in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      held_q  <= held_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign out_instr = held_q ? instr_q : in_instr;
  assign out_pc    = held_q ? pc_q    : in_pc;
  assign held      = held_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Divvy CPU instruction fetch unit.
//                - Sequences the PC and drives the synchronous-read
//                  instruction memory (one-cycle read latency).
//                - Delivers one instruction per cycle to the decoder.
//                - Handles stalls through a hold register.
//                - Taken branches cost one bubble; HLT freezes the unit
//                  until reset.
//  Ports       : CLK, Reset     - clock, synchronous active-high reset
//                Start          - leave IDLE (sampled only in IDLE)
//                Stall          - decoder cannot accept Instr this cycle
//                BranchTaken    - shown instruction is a taken branch
//                BranchTarget   - redirect address
//                Halt           - shown instruction is HLT
//                imem_addr      - memory read address
//                imem_rdata     - memory read data
//                Instr, PC      - instruction word and its address
//                InstrValid     - Instr/PC meaningful
//                Done           - processor halted
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import divvy_pkg::*;
#(
  parameter int              PC_W       = DIVVY_PC_W,
  parameter int              IW         = DIVVY_IW,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Stall,
  input  logic            BranchTaken,
  input  logic [PC_W-1:0] BranchTarget,
  input  logic            Halt,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IW-1:0]   imem_rdata,
  output logic [IW-1:0]   Instr,
  output logic            InstrValid,
  output logic [PC_W-1:0] PC,
  output logic            Done
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;

  logic            run;
  logic            accept;
  logic [IW-1:0]   hold_instr;
  logic [PC_W-1:0] hold_pc;
  logic            hold_full;

  assign run    = (state_q == RUN);
  assign accept = run && !Stall;
  // Natural PC_W-bit wrap: the all-ones address rolls to zero.
  assign pc_inc = pc_q + PC_W'(1);

  fetch_hold #(
    .IW   (IW),
    .PC_W (PC_W)
  ) u_hold (
    .clk       (CLK),
    .rst       (Reset),
    .capture   (run && Stall),
    .clear     (accept),
    .in_instr  (imem_rdata),
    .in_pc     (pc_q),
    .out_instr (hold_instr),
    .out_pc    (hold_pc),
    .held      (hold_full)
  );

  // Next-state and PC update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = START_ADDR;
        end
      end
      RUN: begin
        // Decoder inputs count only on an accepted instruction. Branches
        // raised during a stall are re-presented on acceptance.
        if (accept) begin
          if (Halt) begin
            state_d = HALTED;
          end else if (BranchTaken) begin
            state_d = REDIRECT;
            pc_d    = BranchTarget;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      REDIRECT: begin
        state_d = RUN;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs depend only on registered state and imem_rdata.
  always_comb begin
    imem_addr  = START_ADDR;
    Instr      = '0;
    PC         = pc_q;
    InstrValid = 1'b0;
    Done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        imem_addr = START_ADDR;
      end
      RUN: begin
        // pc_q does not move during a stall, so the address stays at PC+1.
        // After release the next word is already in flight, so no bubble.
        imem_addr  = pc_inc;
        Instr      = hold_instr;
        PC         = hold_pc;
        InstrValid = 1'b1;
      end
      REDIRECT: begin
        // pc_q already holds the target registered at accept.
        imem_addr = pc_q;
      end
      HALTED: begin
        imem_addr = pc_inc;
        Done      = 1'b1;
      end
      default: begin
        imem_addr = START_ADDR;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // hold_full is informational here; the bypass inside fetch_hold uses it.
  logic unused_hold_full;
  assign unused_hold_full = hold_full;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
module tb_instr_fetch;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Main DUT (START_ADDR = 0)
  logic       Reset = 1'b1, Start = 1'b0, Stall = 1'b0, BranchTaken = 1'b0, Halt = 1'b0;
  logic [9:0] BranchTarget = '0;
  logic [9:0] imem_addr, PC;
  logic [8:0] imem_rdata, Instr;
  logic       InstrValid, Done;

  // Wrap DUT (START_ADDR = 0x3FE)
  logic       w_reset = 1'b1, w_start = 1'b0;
  logic [9:0] w_addr, w_pc;
  logic [8:0] w_rdata, w_instr;
  logic       w_valid, w_done;

  logic [8:0] mem [1024];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: observable fetch behaviour
  bit         m_run = 0, m_bub = 0, m_done = 0;
  logic [9:0] m_pc  = '0;

  instr_fetch #(.PC_W(10), .IW(9), .START_ADDR(10'h000)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .Halt(Halt),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .Instr(Instr),
    .InstrValid(InstrValid), .PC(PC), .Done(Done));

  instr_fetch #(.PC_W(10), .IW(9), .START_ADDR(10'h3FE)) dut_w (
    .CLK(CLK), .Reset(w_reset), .Start(w_start), .Stall(1'b0),
    .BranchTaken(1'b0), .BranchTarget(10'h000), .Halt(1'b0),
    .imem_addr(w_addr), .imem_rdata(w_rdata), .Instr(w_instr),
    .InstrValid(w_valid), .PC(w_pc), .Done(w_done));

  // Synchronous-read instruction memory
  always @(posedge CLK) begin
    imem_rdata <= mem[imem_addr];
    w_rdata    <= mem[w_addr];
  end

  // Drive one cycle of inputs, advance the model, land on the next negedge.
  task automatic tick(input logic rst, input logic st, input logic sl,
                      input logic bt, input logic [9:0] tgt, input logic hl);
    Reset = rst; Start = st; Stall = sl; BranchTaken = bt; BranchTarget = tgt; Halt = hl;
    if (rst) begin
      m_run = 0; m_bub = 0; m_done = 0; m_pc = 10'h000;
    end else if (m_done) begin
      m_done = 1;
    end else if (!m_run) begin
      if (st) begin m_run = 1; m_pc = 10'h000; end
    end else if (m_bub) begin
      m_bub = 0;
    end else if (!sl) begin
      if (hl) m_done = 1;
      else if (bt) begin m_bub = 1; m_pc = tgt; end
      else m_pc = m_pc + 10'd1;
    end
    @(negedge CLK);
  endtask

  task automatic test_reset;
    tick(1, 0, 0, 0, 10'h0, 0);
    tick(1, 1, 1, 1, 10'h155, 1);
    n_cmp++; if (InstrValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", InstrValid); end
    n_cmp++; if (Done !== 1'b0)       begin n_bad++; $display("FAIL reset_done: got %b want 0", Done); end
    n_cmp++; if (PC !== 10'h000)      begin n_bad++; $display("FAIL reset_pc: got %h want 000", PC); end
    n_cmp++; if (imem_addr !== 10'h000) begin n_bad++; $display("FAIL reset_addr: got %h want 000", imem_addr); end
    n_cmp++; if (Instr !== 9'h000)    begin n_bad++; $display("FAIL reset_instr: got %h want 000", Instr); end
  endtask

  task automatic test_start_stream;
    logic [8:0] exp;
    tick(1, 0, 0, 0, 10'h0, 0);
    tick(0, 0, 0, 0, 10'h0, 0);
    n_cmp++; if (InstrValid !== 1'b0) begin n_bad++; $display("FAIL idle_valid: got %b want 0", InstrValid); end
    tick(0, 1, 0, 0, 10'h0, 0);
    for (int i = 0; i < 5; i++) begin
      exp = 9'h011 + 9'(i);
      n_cmp++; if (InstrValid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d]: got %b want 1", i, InstrValid); end
      n_cmp++; if (PC !== 10'(i))       begin n_bad++; $display("FAIL stream_pc[%0d]: got %h want %h", i, PC, 10'(i)); end
      n_cmp++; if (Instr !== exp)       begin n_bad++; $display("FAIL stream_instr[%0d]: got %h want %h", i, Instr, exp); end
      tick(0, 0, 0, 0, 10'h0, 0);
    end
  endtask

  task automatic test_stall;
    tick(1, 0, 0, 0, 10'h0, 0);
    tick(0, 1, 0, 0, 10'h0, 0);
    tick(0, 0, 0, 0, 10'h0, 0);
    tick(0, 0, 0, 0, 10'h0, 0);   // showing PC 2
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 0, 10'h0, 0);
      n_cmp++; if (PC !== 10'd2)       begin n_bad++; $display("FAIL stall_pc[%0d]: got %h want 002", i, PC); end
      n_cmp++; if (Instr !== 9'h013)   begin n_bad++; $display("FAIL stall_instr[%0d]: got %h want 013", i, Instr); end
      n_cmp++; if (InstrValid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d]: got %b want 1", i, InstrValid); end
      n_cmp++; if (imem_addr !== 10'd3) begin n_bad++; $display("FAIL stall_addr[%0d]: got %h want 003", i, imem_addr); end
    end
    tick(0, 0, 0, 0, 10'h0, 0);
    n_cmp++; if (PC !== 10'd3)     begin n_bad++; $display("FAIL release_pc: got %h want 003", PC); end
    n_cmp++; if (Instr !== 9'h014) begin n_bad++; $display("FAIL release_instr: got %h want 014", Instr); end
    n_cmp++; if (InstrValid !== 1'b1) begin n_bad++; $display("FAIL release_valid: got %b want 1", InstrValid); end
  endtask

  task automatic test_branch;
    tick(1, 0, 0, 0, 10'h0, 0);
    tick(0, 1, 0, 0, 10'h0, 0);
    tick(0, 0, 0, 0, 10'h0, 0);          // showing PC 1
    tick(0, 0, 0, 1, 10'h120, 0);
    n_cmp++; if (InstrValid !== 1'b0)    begin n_bad++; $display("FAIL br_bubble_valid: got %b want 0", InstrValid); end
    n_cmp++; if (imem_addr !== 10'h120)  begin n_bad++; $display("FAIL br_bubble_addr: got %h want 120", imem_addr); end
    tick(0, 1, 1, 1, 10'h055, 1);        // all ignored in the bubble
    n_cmp++; if (InstrValid !== 1'b1)    begin n_bad++; $display("FAIL br_tgt_valid: got %b want 1", InstrValid); end
    n_cmp++; if (PC !== 10'h120)         begin n_bad++; $display("FAIL br_tgt_pc: got %h want 120", PC); end
    n_cmp++; if (Instr !== mem[10'h120]) begin n_bad++; $display("FAIL br_tgt_instr: got %h want %h", Instr, mem[10'h120]); end
    n_cmp++; if (Done !== 1'b0)          begin n_bad++; $display("FAIL br_tgt_done: got %b want 0", Done); end
    tick(0, 0, 1, 1, 10'h077, 0);        // branch under stall ignored
    tick(0, 0, 0, 0, 10'h0, 0);
    n_cmp++; if (InstrValid !== 1'b1)    begin n_bad++; $display("FAIL br_stall_valid: got %b want 1", InstrValid); end
    n_cmp++; if (PC !== 10'h121)         begin n_bad++; $display("FAIL br_stall_pc: got %h want 121", PC); end
  endtask

  task automatic test_halt;
    tick(1, 0, 0, 0, 10'h0, 0);
    tick(0, 1, 0, 0, 10'h0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 10'h0, 0);   // showing PC 3
    tick(0, 0, 0, 1, 10'h200, 1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (Done !== 1'b1)       begin n_bad++; $display("FAIL halt_done[%0d]: got %b want 1", i, Done); end
      n_cmp++; if (InstrValid !== 1'b0) begin n_bad++; $display("FAIL halt_valid[%0d]: got %b want 0", i, InstrValid); end
      n_cmp++; if (PC !== 10'd3)        begin n_bad++; $display("FAIL halt_pc[%0d]: got %h want 003", i, PC); end
      tick(0, 1, 1'(i), 1, 10'h011, 0);
    end
  endtask

  task automatic test_wrap;
    w_reset = 1'b1; @(negedge CLK);
    w_reset = 1'b0; w_start = 1'b1; @(negedge CLK);
    w_start = 1'b0;
    n_cmp++; if (w_pc !== 10'h3FE || w_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_pc0: got %h/%b want 3fe/1", w_pc, w_valid); end
    n_cmp++; if (w_instr !== mem[10'h3FE]) begin n_bad++; $display("FAIL wrap_instr0: got %h want %h", w_instr, mem[10'h3FE]); end
    @(negedge CLK);
    n_cmp++; if (w_pc !== 10'h3FF) begin n_bad++; $display("FAIL wrap_pc1: got %h want 3ff", w_pc); end
    @(negedge CLK);
    n_cmp++; if (w_pc !== 10'h000) begin n_bad++; $display("FAIL wrap_pc2: got %h want 000", w_pc); end
    n_cmp++; if (w_instr !== 9'h011) begin n_bad++; $display("FAIL wrap_instr2: got %h want 011", w_instr); end
  endtask

  task automatic test_mid_reset;
    tick(1, 0, 0, 0, 10'h0, 0);
    tick(0, 1, 0, 0, 10'h0, 0);
    tick(0, 0, 0, 0, 10'h0, 0);
    tick(0, 0, 1, 0, 10'h0, 0);          // mid-stall
    tick(1, 0, 1, 0, 10'h0, 0);
    n_cmp++; if (InstrValid !== 1'b0 || Done !== 1'b0) begin n_bad++; $display("FAIL mrst_stall_vd: got %b%b want 00", InstrValid, Done); end
    n_cmp++; if (PC !== 10'h000 || imem_addr !== 10'h000) begin n_bad++; $display("FAIL mrst_stall_pa: got %h/%h want 000/000", PC, imem_addr); end
    n_cmp++; if (Instr !== 9'h000) begin n_bad++; $display("FAIL mrst_stall_instr: got %h want 000", Instr); end
    tick(0, 1, 0, 0, 10'h0, 0);
    n_cmp++; if (Instr !== 9'h011 || PC !== 10'h000 || InstrValid !== 1'b1) begin n_bad++; $display("FAIL mrst_restart1: got %h/%h/%b want 011/000/1", Instr, PC, InstrValid); end
    tick(0, 0, 0, 1, 10'h120, 0);        // into REDIRECT
    tick(1, 0, 0, 0, 10'h0, 0);
    n_cmp++; if (InstrValid !== 1'b0 || PC !== 10'h000 || imem_addr !== 10'h000) begin n_bad++; $display("FAIL mrst_redir: got %b/%h/%h want 0/000/000", InstrValid, PC, imem_addr); end
    tick(0, 1, 0, 0, 10'h0, 0);
    n_cmp++; if (Instr !== 9'h011 || PC !== 10'h000 || InstrValid !== 1'b1) begin n_bad++; $display("FAIL mrst_restart2: got %h/%h/%b want 011/000/1", Instr, PC, InstrValid); end
  endtask

  task automatic test_random;
    tick(1, 0, 0, 0, 10'h0, 0);
    for (int c = 0; c < 600; c++) begin
      logic r, s, sl, b, h;
      logic [9:0] t;
      bit exp_v;
      r  = m_done ? ($urandom_range(3) == 0) : ($urandom_range(80) == 0);
      s  = 1'($urandom_range(1));
      sl = ($urandom_range(9) < 3);
      b  = ($urandom_range(6) == 0);
      t  = 10'($urandom);
      h  = ($urandom_range(50) == 0);
      tick(r, s, sl, b, t, h);
      exp_v = m_run && !m_bub && !m_done;
      n_cmp++; if (InstrValid !== exp_v) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, InstrValid, exp_v); end
      n_cmp++; if (Done !== m_done)      begin n_bad++; $display("FAIL rnd_done[%0d]: got %b want %b", c, Done, m_done); end
      if (exp_v) begin
        n_cmp++; if (PC !== m_pc)          begin n_bad++; $display("FAIL rnd_pc[%0d]: got %h want %h", c, PC, m_pc); end
        n_cmp++; if (Instr !== mem[m_pc])  begin n_bad++; $display("FAIL rnd_instr[%0d]: got %h want %h", c, Instr, mem[m_pc]); end
      end
      if (m_bub) begin
        n_cmp++; if (imem_addr !== m_pc)   begin n_bad++; $display("FAIL rnd_redir_addr[%0d]: got %h want %h", c, imem_addr, m_pc); end
      end
      if (!m_run) begin
        n_cmp++; if (imem_addr !== 10'h000) begin n_bad++; $display("FAIL rnd_idle_addr[%0d]: got %h want 000", c, imem_addr); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 9'($urandom);
    for (int i = 0; i < 5; i++) mem[i] = 9'h011 + 9'(i);
    @(negedge CLK);
    test_reset();
    test_start_stream();
    test_stall();
    test_branch();
    test_halt();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
